// File: rtl/echo_request_output.sv
// Transmit-side portal encoder: packs say/say2 calls into {word2, word1, tag}, queues them, and emits three 32-bit beats per message.
// Optional message counter output enabled by defining ECHO_REQUEST_OUTPUT_STATS_EN.
`timescale 1ns/1ps
module echo_request_output #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] TAG_SAY  = 32'd0,
    parameter logic [31:0] TAG_SAY2 = 32'd1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        request_say__ENA,
    input  logic [31:0] request_say_meth,
    input  logic [31:0] request_say_v,
    output logic        request_say__RDY,
    input  logic        request_say2__ENA,
    input  logic [31:0] request_say2_a,
    input  logic [31:0] request_say2_b,
    output logic        request_say2__RDY,
    output logic        pipe_enq__ENA,
    output logic [31:0] pipe_enq_v,
    output logic        pipe_enq_last,
    input  logic        pipe_enq__RDY
`ifdef ECHO_REQUEST_OUTPUT_STATS_EN
    ,
    output logic [31:0] msg_count
`endif
);

    localparam int unsigned W     = 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [W-1:0] word2;
        logic [W-1:0] word1;
        logic [W-1:0] tag;
    } msg_t;

    typedef enum logic [1:0] {
        BEAT_TAG = 2'd0,
        BEAT_W1  = 2'd1,
        BEAT_W2  = 2'd2
    } beat_e;

    msg_t              mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    beat_e             beat_q, beat_d;

    logic              say_ok, say2_ok;
    logic              wr0_en, wr1_en;
    msg_t              wr0_data, wr1_data;
    logic [PTR_W-1:0]  wr1_ptr;
    logic [CNT_W-1:0]  n_push;
    logic [CNT_W-1:0]  free_d;
    logic              advance, pop;
    msg_t              head_d;
    logic              ena_d, last_d, say_rdy_d, say2_rdy_d;
    logic [W-1:0]      v_d;

    // Next-state: enqueue, beat sequencing, and the output values for the following cycle
    always_comb begin
        say_ok     = 1'b0;
        say2_ok    = 1'b0;
        wr0_en     = 1'b0;
        wr1_en     = 1'b0;
        wr0_data   = '0;
        wr1_data   = '0;
        wr1_ptr    = '0;
        n_push     = '0;
        advance    = 1'b0;
        pop        = 1'b0;
        beat_d     = beat_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        head_d     = '0;
        free_d     = '0;
        ena_d      = 1'b0;
        v_d        = '0;
        last_d     = 1'b0;
        say_rdy_d  = 1'b0;
        say2_rdy_d = 1'b0;

        // Calls made while not ready are dropped
        say_ok   = request_say__ENA & request_say__RDY;
        say2_ok  = request_say2__ENA & request_say2__RDY;
        wr0_en   = say_ok | say2_ok;
        wr1_en   = say_ok & say2_ok;
        wr0_data = say_ok ? {request_say_v, request_say_meth, TAG_SAY}
                          : {request_say2_b, request_say2_a, TAG_SAY2};
        wr1_data = {request_say2_b, request_say2_a, TAG_SAY2};
        wr1_ptr  = wr_ptr_q + PTR_W'(1);
        n_push   = CNT_W'(wr0_en) + CNT_W'(wr1_en);

        advance = pipe_enq__ENA & pipe_enq__RDY;
        pop     = advance & (beat_q == BEAT_W2);
        if (advance) begin
            case (beat_q)
                BEAT_TAG: beat_d = BEAT_W1;
                BEAT_W1:  beat_d = BEAT_W2;
                default:  beat_d = BEAT_TAG;
            endcase
        end

        count_d  = count_q - CNT_W'(pop) + n_push;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_push);

        // A slot written this cycle can only become head when the FIFO was drained
        head_d = mem_q[rd_ptr_d];
        if (wr0_en && (wr_ptr_q == rd_ptr_d)) head_d = wr0_data;
        if (wr1_en && (wr1_ptr == rd_ptr_d))  head_d = wr1_data;

        ena_d = (count_d != '0);
        if (ena_d) begin
            case (beat_d)
                BEAT_TAG: v_d = head_d.tag;
                BEAT_W1:  v_d = head_d.word1;
                default:  v_d = head_d.word2;
            endcase
        end
        last_d = ena_d & (beat_d == BEAT_W2);

        free_d     = CNT_W'(DEPTH) - count_d;
        say_rdy_d  = (free_d >= CNT_W'(1));
        say2_rdy_d = (free_d >= CNT_W'(2));
    end

    // State and registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q           <= '0;
            rd_ptr_q          <= '0;
            wr_ptr_q          <= '0;
            beat_q            <= BEAT_TAG;
            pipe_enq__ENA     <= 1'b0;
            pipe_enq_v        <= '0;
            pipe_enq_last     <= 1'b0;
            request_say__RDY  <= 1'b1;
            request_say2__RDY <= 1'b1;
        end else begin
            count_q           <= count_d;
            rd_ptr_q          <= rd_ptr_d;
            wr_ptr_q          <= wr_ptr_d;
            beat_q            <= beat_d;
            pipe_enq__ENA     <= ena_d;
            pipe_enq_v        <= v_d;
            pipe_enq_last     <= last_d;
            request_say__RDY  <= say_rdy_d;
            request_say2__RDY <= say2_rdy_d;
        end
    end

    // Message storage; say lands before say2 when both arrive together
    always_ff @(posedge CLK) begin
        if (wr0_en) mem_q[wr_ptr_q] <= wr0_data;
        if (wr1_en) mem_q[wr1_ptr]  <= wr1_data;
    end

`ifdef ECHO_REQUEST_OUTPUT_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            msg_count <= '0;
        end else if (advance && pipe_enq_last) begin
            msg_count <= msg_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_echo_request_output.sv
// Directed self-checking bench for echo_request_output.
`timescale 1ns/1ps
module tb_echo_request_output;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        say_ena = 1'b0;
    logic [31:0] say_meth = '0;
    logic [31:0] say_v = '0;
    logic        say_rdy;
    logic        say2_ena = 1'b0;
    logic [31:0] say2_a = '0;
    logic [31:0] say2_b = '0;
    logic        say2_rdy;
    logic        enq_ena;
    logic [31:0] enq_v;
    logic        enq_last;
    logic        enq_rdy = 1'b0;
`ifdef ECHO_REQUEST_OUTPUT_STATS_EN
    logic [31:0] msg_count;
`endif

    int errors = 0;
    int checks = 0;

    echo_request_output dut (
        .CLK               (clk),
        .nRST              (rst_n),
        .request_say__ENA  (say_ena),
        .request_say_meth  (say_meth),
        .request_say_v     (say_v),
        .request_say__RDY  (say_rdy),
        .request_say2__ENA (say2_ena),
        .request_say2_a    (say2_a),
        .request_say2_b    (say2_b),
        .request_say2__RDY (say2_rdy),
        .pipe_enq__ENA     (enq_ena),
        .pipe_enq_v        (enq_v),
        .pipe_enq_last     (enq_last),
        .pipe_enq__RDY     (enq_rdy)
`ifdef ECHO_REQUEST_OUTPUT_STATS_EN
        ,
        .msg_count         (msg_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Calling a method while it is not ready is illegal
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!((say_ena && !say_rdy) || (say2_ena && !say2_rdy))) else begin
                errors++;
                $error("FAIL illegal_call: say_ena=%b say_rdy=%b say2_ena=%b say2_rdy=%b",
                       say_ena, say_rdy, say2_ena, say2_rdy);
            end
        end
    end

    initial begin
        #100000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_v3 [6];
        logic        rdy_seq [5];
        logic [31:0] exp_v2 [5];
        logic        exp_l2 [5];
        int          accepted;

        // Reset state
        tick();
        check("reset_ena",  32'(enq_ena), 32'd0);
        check("reset_v",    enq_v, 32'd0);
        check("reset_last", 32'(enq_last), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("empty_say_rdy",  32'(say_rdy), 32'd1);
        check("empty_say2_rdy", 32'(say2_rdy), 32'd1);
        check("empty_ena",      32'(enq_ena), 32'd0);

        // Single say, downstream always ready
        enq_rdy  = 1'b1;
        say_ena  = 1'b1;
        say_meth = 32'h11;
        say_v    = 32'h22;
        tick();
        say_ena = 1'b0;
        check("t1_ena0",  32'(enq_ena), 32'd1);
        check("t1_v0",    enq_v, 32'h0);
        check("t1_last0", 32'(enq_last), 32'd0);
        tick();
        check("t1_v1",    enq_v, 32'h11);
        check("t1_last1", 32'(enq_last), 32'd0);
        tick();
        check("t1_v2",    enq_v, 32'h22);
        check("t1_last2", 32'(enq_last), 32'd1);
        tick();
        check("t1_idle_ena",  32'(enq_ena), 32'd0);
        check("t1_idle_last", 32'(enq_last), 32'd0);

        // say2 with downstream ready toggling
        say2_ena = 1'b1;
        say2_a   = 32'hA;
        say2_b   = 32'hB;
        tick();
        say2_ena = 1'b0;
        rdy_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_v2  = '{32'h1, 32'hA, 32'hA, 32'hB, 32'hB};
        exp_l2  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        accepted = 0;
        for (int k = 0; k < 5; k++) begin
            enq_rdy = rdy_seq[k];
            check($sformatf("t2_ena%0d", k),  32'(enq_ena), 32'd1);
            check($sformatf("t2_v%0d", k),    enq_v, exp_v2[k]);
            check($sformatf("t2_last%0d", k), 32'(enq_last), 32'(exp_l2[k]));
            if (enq_ena && enq_rdy) accepted++;
            tick();
        end
        check("t2_accepted", 32'(accepted), 32'd3);
        check("t2_idle_ena", 32'(enq_ena), 32'd0);

        // Same-cycle say and say2 from empty
        enq_rdy  = 1'b1;
        say_ena  = 1'b1;
        say_meth = 32'h1;
        say_v    = 32'h2;
        say2_ena = 1'b1;
        say2_a   = 32'h3;
        say2_b   = 32'h4;
        tick();
        say_ena  = 1'b0;
        say2_ena = 1'b0;
        exp_v3 = '{32'h0, 32'h1, 32'h2, 32'h1, 32'h3, 32'h4};
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t3_v%0d", k),    enq_v, exp_v3[k]);
            check($sformatf("t3_last%0d", k), 32'(enq_last), 32'((k % 3) == 2));
            tick();
        end
        check("t3_idle_ena", 32'(enq_ena), 32'd0);

        // Fill the FIFO with downstream stalled
        enq_rdy  = 1'b0;
        accepted = 0;
        for (int k = 0; k < 8; k++) begin
            if (!say_rdy) break;
            say_ena  = 1'b1;
            say_meth = 32'h100 + 32'(accepted);
            say_v    = 32'h200 + 32'(accepted);
            tick();
            accepted++;
            check($sformatf("t4_say2_rdy_at%0d", accepted), 32'(say2_rdy), 32'(accepted <= 2));
        end
        say_ena = 1'b0;
        check("t4_accepted", 32'(accepted), 32'd4);
        check("t4_full_say_rdy", 32'(say_rdy), 32'd0);
        tick();
        check("t4_stall_ena", 32'(enq_ena), 32'd1);
        check("t4_stall_v",   enq_v, 32'h0);
        enq_rdy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic [31:0] ev;
            case (k % 3)
                0:       ev = 32'h0;
                1:       ev = 32'h100 + 32'(k / 3);
                default: ev = 32'h200 + 32'(k / 3);
            endcase
            check($sformatf("t4_v%0d", k),    enq_v, ev);
            check($sformatf("t4_last%0d", k), 32'(enq_last), 32'((k % 3) == 2));
            tick();
        end
        check("t4_idle_ena", 32'(enq_ena), 32'd0);
        check("t4_drained_say_rdy", 32'(say_rdy), 32'd1);

`ifdef ECHO_REQUEST_OUTPUT_STATS_EN
        check("stats_msg_count", msg_count, 32'd8);
`endif

        // Reset in the middle of a message
        say_ena  = 1'b1;
        say_meth = 32'h55;
        say_v    = 32'h66;
        tick();
        say_ena = 1'b0;
        check("t5_v0", enq_v, 32'h0);
        tick();
        check("t5_v1", enq_v, 32'h55);
        rst_n = 1'b0;
        #1;
        check("t5_async_ena",  32'(enq_ena), 32'd0);
        check("t5_async_v",    enq_v, 32'h0);
        check("t5_async_last", 32'(enq_last), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t5_quiet%0d", k), 32'(enq_ena), 32'd0);
        end
        check("t5_say_rdy", 32'(say_rdy), 32'd1);
        say_ena  = 1'b1;
        say_meth = 32'h77;
        say_v    = 32'h88;
        tick();
        say_ena = 1'b0;
        check("t5_new_ena", 32'(enq_ena), 32'd1);
        check("t5_new_v0",  enq_v, 32'h0);
        tick();
        check("t5_new_v1",  enq_v, 32'h77);
        tick();
        check("t5_new_v2",  enq_v, 32'h88);
        check("t5_new_last", 32'(enq_last), 32'd1);
        tick();
        check("t5_idle_ena", 32'(enq_ena), 32'd0);

`ifdef ECHO_REQUEST_OUTPUT_STATS_EN
        check("stats_after_reset", msg_count, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/echo_request_output.md
Name: echo_request_output

Overview:
- Transmit-side encoder of the portal pipe.
- Accepts request$say / request$say2 method calls and packs each into a 96-bit message {word2, word1, tag}.
- Buffers messages in a DEPTH-entry FIFO, then serializes each one as three 32-bit beats onto pipe$enq toward the transport.
- It is the encoder/transmitter counterpart of the indication-side decoder, which matches the tag and unpacks fields.

Parameters:
- DEPTH, 4, FIFO depth in messages; power of two, minimum 2.
- TAG_SAY, 0, 32-bit method tag for say.
- TAG_SAY2, 1, 32-bit method tag for say2.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  reset; asynchronous assert, active-low.
- request$say__ENA  input  1  say call strobe.
- request$say$meth  input  32  say arg 1 -> word1.
- request$say$v  input  32  say arg 2 -> word2.
- request$say__RDY  output  1  say may be called.
- request$say2__ENA  input  1  say2 call strobe.
- request$say2$a  input  32  say2 arg 1 -> word1.
- request$say2$b  input  32  say2 arg 2 -> word2.
- request$say2__RDY  output  1  say2 may be called.
- pipe$enq__ENA  output  1  beat valid.
- pipe$enq$v  output  32  beat data.
- pipe$enq$last  output  1  final beat of message.
- pipe$enq__RDY  input  1  downstream accepts beat.

Behaviour:
- Reset (nRST low, async):
  - FIFO count=0, read/write pointers=0, beat index=0.
  - pipe$enq__ENA=0, pipe$enq$last=0, pipe$enq$v=0.
  - RDY outputs reflect an empty FIFO after release.
- Readiness, where free = DEPTH - count:
  - request$say__RDY = (free >= 1).
  - request$say2__RDY = (free >= 2), which reserves room so a simultaneous say+say2 always fits.
  - RDY is a function of registered state only, never of any ENA.
- Calling an ENA while its RDY=0 is illegal. The bench asserts on it; RTL ignores that call.
- Enqueue:
  - say stores {v, meth, TAG_SAY}; say2 stores {b, a, TAG_SAY2}.
  - Both in the same cycle: say is written first, say2 second; count += 2.
- Latency: a message accepted at edge N presents its beat 0 on pipe from cycle N+1. No combinational path from request to pipe.
- Serializer: beat index idx in {0,1,2}.
  - pipe$enq__ENA = (count != 0).
  - pipe$enq$v = head word[idx] (idx 0 = tag, 1 = word1, 2 = word2).
  - pipe$enq$last = ENA & (idx == 2).
  - On ENA & RDY: if idx < 2, idx++; else idx = 0 and the head is popped.
  - pipe$enq__ENA never depends on pipe$enq__RDY.
  - While RDY=0, v and last hold stable.
- Simultaneous pop and push(es) in one cycle: count = count - 1 + pushes. Readiness is computed from the pre-edge count, so a full FIFO stays not-ready that cycle even if it pops.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never exceeds DEPTH.
- Reset mid-message: the partial message is discarded, idx returns to 0, and no further beats are emitted until a new enqueue.

Optional Feature:
- Macro ECHO_REQUEST_OUTPUT_STATS_EN.
- Defined:
  - Adds output port msg_count (32 bits).
  - msg_count increments by 1 on each accepted last beat (ENA & RDY & last).
  - Resets to 0 and wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single say (meth=0x11, v=0x22), pipe$enq__RDY held 1 -> beats 0x0, 0x11, 0x22 on cycles N+1..N+3; last=1 only on 0x22; FIFO then empty, ENA=0.
- say2 (a=0xA, b=0xB) with RDY toggling 1,0,1,0,1 -> beats 0x1, 0xA, 0xB; each beat held stable while RDY=0; exactly 3 beats accepted.
- Same-cycle say (0x1,0x2) and say2 (0x3,0x4) from empty -> order 0x0,0x1,0x2 then 0x1,0x3,0x4; count peaks at 2.
- RDY=0 downstream; issue say calls until say__RDY=0 -> exactly DEPTH=4 accepted; say2__RDY drops when count reaches 3; after release, 12 beats emitted in order.
- nRST pulsed low after beat 1 of a message -> ENA=0 immediately (async); no beats emitted after release until a new say; next message starts at tag beat.
- With ECHO_REQUEST_OUTPUT_STATS_EN, send 5 messages -> msg_count=5; counter preloaded to 0xFFFFFFFF plus one message -> 0.
